// File: rtl/acc_burst_sequencer.sv
// Command sequencer for the selectable-adder / feedback-accumulator datapath:
// clears the accumulator, streams N operand pairs, then returns the final sum.
module acc_burst_sequencer #(
  parameter int DATA_W = 3,
  parameter int SEL_W  = 2,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [SEL_W-1:0]  i_op_sel,
  output logic              o_busy,
  input  logic              i_op_valid,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_op_ready,
  output logic [DATA_W-1:0] o_dp_data1,
  output logic [DATA_W-1:0] o_dp_data2,
  output logic [SEL_W-1:0]  o_dp_sel,
  output logic              o_dp_rst_n,
  input  logic [ACC_W-1:0]  i_dp_acc,
  input  logic              i_dp_overflow,
  output logic              o_res_valid,
  output logic [ACC_W-1:0]  o_res_data,
  output logic              o_res_overflow,
  input  logic              i_res_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dp_rst_q;
  logic               sticky_q;
  logic [ACC_W-1:0]   res_data_q;
  logic               res_ovf_q;
  logic               accept;

  assign o_busy         = (state != S_IDLE);
  assign o_op_ready     = (state == S_RUN);
  assign o_res_valid    = (state == S_DONE);
  assign accept         = i_op_valid & o_op_ready;
  assign o_dp_sel       = sel_q;
  assign o_dp_rst_n     = dp_rst_q;
  assign o_res_data     = res_data_q;
  assign o_res_overflow = res_ovf_q;

  // Zero operands outside accepted beats keep the accumulator still.
  assign o_dp_data1 = accept ? i_op_a : '0;
  assign o_dp_data2 = accept ? i_op_b : '0;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (i_start) state_n = S_CLEAR;
      S_CLEAR: state_n = (cnt_q != '0) ? S_RUN : S_DRAIN;
      S_RUN:   if (accept && cnt_q == CNT_W'(1)) state_n = S_DRAIN;
      S_DRAIN: state_n = S_DONE;
      S_DONE:  if (i_res_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      dp_rst_q <= 1'b0;
    end else begin
      state    <= state_n;
      dp_rst_q <= (state_n != S_CLEAR);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else if (state == S_IDLE && i_start) begin
      sel_q <= i_op_sel;
      cnt_q <= i_count;
    end else if (accept) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Overflow pulses from the datapath are folded in until the capture.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q   <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      if (state == S_CLEAR)
        sticky_q <= 1'b0;
      else if (state == S_RUN)
        sticky_q <= sticky_q | i_dp_overflow;
      if (state == S_DRAIN) begin
        res_data_q <= i_dp_acc;
        res_ovf_q  <= sticky_q | i_dp_overflow;
      end
    end
  end

endmodule
